// File: rtl/bus_pkg.sv
// Shared constants and types for the bus time-slice scheduler.
package bus_pkg;

    // Slot start phases within the 16-phase CPU cycle
    localparam logic [3:0] PHASE_VID       = 4'd2;
    localparam logic [3:0] PHASE_SPI       = 4'd4;
    localparam logic [3:0] PHASE_SPI_BONUS = 4'd10;
    localparam logic [3:0] PHASE_CPU       = 4'd8;

    // Length in clocks of the video and SPI slots
    localparam logic [3:0] SLOT_LEN = 4'd2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE,
        RELEASE
    } spi_state_t;

    // True when phase lies inside the slot that begins at start
    function automatic logic in_slot(input logic [3:0] phase, input logic [3:0] start);
        logic [3:0] offset;
        offset = phase - start;
        return offset < SLOT_LEN;
    endfunction

endpackage

// File: rtl/bus_phase_gen.sv
// Phase counter for the 16-clock CPU cycle plus the derived 1 MHz CPU clock.
module bus_phase_gen (
    input  logic       clk_i,
    input  logic       reset_i,
    output logic [3:0] phase_o,
    output logic [3:0] phase_next_o,
    output logic       clk_cpu_o
);

    logic [3:0] phase_q;
    logic       clk_cpu_q;

    // Next phase; the scheduler decodes its registered outputs from this value
    always_comb begin
        phase_next_o = phase_q + 4'd1;
    end

    // Phase counter and phi2 register (high during phases 8-15)
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q   <= 4'd0;
            clk_cpu_q <= 1'b0;
        end else begin
            phase_q   <= phase_next_o;
            clk_cpu_q <= phase_next_o[3];
        end
    end

    assign phase_o   = phase_q;
    assign clk_cpu_o = clk_cpu_q;

endmodule

// File: rtl/bus_scheduler.sv
// Time-slices the shared bus between video, SPI bridge and CPU within each CPU cycle.
module bus_scheduler
    import bus_pkg::*;
#(
    parameter bit SPI_BONUS_EN = 1'b1,
    parameter bit VID_EN       = 1'b1
) (
    input  logic       clk_16_i,
    input  logic       reset_i,
    input  logic       cpu_valid_i,
    output logic       clk_cpu_o,
    output logic       cpu_enable_o,
    input  logic       spi_valid_i,
    output logic       spi_enable_o,
    output logic       spi_ready_o,
    input  logic       vid_valid_i,
    output logic       vid_enable_o,
    output logic       vid_strobe_o,
    output logic [3:0] phase_o
);

    // Request sample points sit one clock before the slot they feed
    localparam logic [3:0] VID_SAMPLE   = PHASE_VID - 4'd1;
    localparam logic [3:0] SPI_SAMPLE   = PHASE_SPI - 4'd1;
    localparam logic [3:0] BONUS_SAMPLE = PHASE_SPI_BONUS - 4'd1;
    localparam logic [3:0] CPU_SAMPLE   = PHASE_CPU - 4'd1;
    localparam logic [3:0] VID_LAST     = PHASE_VID + SLOT_LEN - 4'd1;
    localparam logic [3:0] SPI_LAST     = PHASE_SPI + SLOT_LEN - 4'd1;
    localparam logic [3:0] BONUS_LAST   = PHASE_SPI_BONUS + SLOT_LEN - 4'd1;

    logic [3:0] phase_q;
    logic [3:0] phase_d;

    logic       cpu_grant_q, cpu_grant_d;
    logic       cpu_enable_q, cpu_enable_d;
    logic       vid_enable_q, vid_enable_d;
    logic       vid_strobe_q, vid_strobe_d;
    logic       spi_enable_q, spi_ready_q;
    spi_state_t state_q, state_d;

    bus_phase_gen u_phase_gen (
        .clk_i        (clk_16_i),
        .reset_i      (reset_i),
        .phase_o      (phase_q),
        .phase_next_o (phase_d),
        .clk_cpu_o    (clk_cpu_o)
    );

    // CPU and video grant decode against the next phase
    always_comb begin
        cpu_grant_d = cpu_grant_q;
        if (phase_q == CPU_SAMPLE) begin
            cpu_grant_d = cpu_valid_i;
        end
        cpu_enable_d = (phase_d >= PHASE_CPU) && cpu_grant_d;

        vid_enable_d = 1'b0;
        if (VID_EN) begin
            if (phase_q == VID_SAMPLE) begin
                vid_enable_d = vid_valid_i;
            end else if (in_slot(phase_d, PHASE_VID)) begin
                vid_enable_d = vid_enable_q;
            end
        end
        vid_strobe_d = vid_enable_d && (phase_d == VID_LAST);
    end

    // SPI access FSM: grant on a sample point, pulse ready, hold off until valid drops
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (spi_valid_i && (phase_q == SPI_SAMPLE)) begin
                    state_d = GRANT;
                end else if (SPI_BONUS_EN && spi_valid_i && !cpu_grant_q &&
                             (phase_q == BONUS_SAMPLE)) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if ((phase_q == SPI_LAST) || (phase_q == BONUS_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A command dropped during the access needs no release wait
                state_d = spi_valid_i ? RELEASE : IDLE;
            end
            RELEASE: begin
                if (!spi_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SPI state register
    always_ff @(posedge clk_16_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered grant outputs, aligned with phase_q
    always_ff @(posedge clk_16_i or posedge reset_i) begin
        if (reset_i) begin
            cpu_grant_q  <= 1'b0;
            cpu_enable_q <= 1'b0;
            vid_enable_q <= 1'b0;
            vid_strobe_q <= 1'b0;
            spi_enable_q <= 1'b0;
            spi_ready_q  <= 1'b0;
        end else begin
            cpu_grant_q  <= cpu_grant_d;
            cpu_enable_q <= cpu_enable_d;
            vid_enable_q <= vid_enable_d;
            vid_strobe_q <= vid_strobe_d;
            spi_enable_q <= (state_d == GRANT);
            spi_ready_q  <= (state_d == DONE);
        end
    end

    assign cpu_enable_o = cpu_enable_q;
    assign vid_enable_o = vid_enable_q;
    assign vid_strobe_o = vid_strobe_q;
    assign spi_enable_o = spi_enable_q;
    assign spi_ready_o  = spi_ready_q;
    assign phase_o      = phase_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed self-checking bench for bus_scheduler.
module tb_bus_scheduler;

    logic       clk_16;
    logic       reset;
    logic       cpu_valid;
    logic       clk_cpu;
    logic       cpu_enable;
    logic       spi_valid;
    logic       spi_enable;
    logic       spi_ready;
    logic       vid_valid;
    logic       vid_enable;
    logic       vid_strobe;
    logic [3:0] phase;

    int checks = 0;
    int errors = 0;
    int tph    = 0;

    bus_scheduler #(
        .SPI_BONUS_EN (1'b1),
        .VID_EN       (1'b1)
    ) dut (
        .clk_16_i     (clk_16),
        .reset_i      (reset),
        .cpu_valid_i  (cpu_valid),
        .clk_cpu_o    (clk_cpu),
        .cpu_enable_o (cpu_enable),
        .spi_valid_i  (spi_valid),
        .spi_enable_o (spi_enable),
        .spi_ready_o  (spi_ready),
        .vid_valid_i  (vid_valid),
        .vid_enable_o (vid_enable),
        .vid_strobe_o (vid_strobe),
        .phase_o      (phase)
    );

    initial clk_16 = 1'b0;
    always #5 clk_16 = ~clk_16;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @phase %0d: observed %0h expected %0h", tag, tph, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 ns later, and check the free-running phase/clock
    task automatic tick();
        @(posedge clk_16);
        #1;
        tph = (tph + 1) % 16;
        check("phase", 32'(phase), 32'(tph));
        check("clk_cpu", 32'(clk_cpu), 32'(tph >= 8));
    endtask

    task automatic expect_outs(input bit cpu, input bit spi, input bit rdy, input bit vid,
                               input bit stb);
        check("cpu_enable", 32'(cpu_enable), 32'(cpu));
        check("spi_enable", 32'(spi_enable), 32'(spi));
        check("spi_ready", 32'(spi_ready), 32'(rdy));
        check("vid_enable", 32'(vid_enable), 32'(vid));
        check("vid_strobe", 32'(vid_strobe), 32'(stb));
        check("onehot", 32'($countones({cpu_enable, spi_enable, vid_enable}) <= 1), 32'd1);
    endtask

    // No SPI/video traffic expected; CPU owns phases 8-15 when cpu_on
    task automatic run_plain(input int n, input bit cpu_on);
        for (int i = 0; i < n; i++) begin
            tick();
            expect_outs(cpu_on && (tph >= 8), 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset state
        reset     = 1'b1;
        cpu_valid = 1'b1;
        spi_valid = 1'b0;
        vid_valid = 1'b0;
        #1;
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_clk_cpu", 32'(clk_cpu), 32'd0);
        expect_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        tph   = 0;

        // CPU run: two full cycles, first edge lands on phase 1
        run_plain(32, 1'b1);

        // SPI during CPU run, held 48 clocks: one grant only
        spi_valid = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick();
            expect_outs(tph >= 8, (k == 4) || (k == 5), k == 6, 1'b0, 1'b0);
        end
        spi_valid = 1'b0;
        run_plain(4, 1'b1);

        // Late request rising at phase 4: grant next cycle, ready 18 clocks later
        spi_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            expect_outs(tph >= 8, (k == 16) || (k == 17), k == 18, 1'b0, 1'b0);
        end
        spi_valid = 1'b0;
        cpu_valid = 1'b0;
        run_plain(8, 1'b1);

        // Bonus slot with CPU halted: two commands in one CPU cycle
        spi_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            expect_outs(1'b0, (k == 4) || (k == 5) || (k == 10) || (k == 11),
                        (k == 6) || (k == 12), 1'b0, 1'b0);
            if (k == 7) spi_valid = 1'b0;
            if (k == 8) spi_valid = 1'b1;
            if (k == 13) spi_valid = 1'b0;
        end

        // Video + SPI + CPU all requesting for 100 CPU cycles
        cpu_valid = 1'b1;
        vid_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            spi_valid = 1'b1;
            for (int k = 1; k <= 16; k++) begin
                tick();
                expect_outs(tph >= 8, (tph == 4) || (tph == 5), tph == 6,
                            (tph == 2) || (tph == 3), tph == 3);
                if (tph == 7) spi_valid = 1'b0;
            end
        end
        vid_valid = 1'b0;

        // Reset at phase 4 of an SPI grant, command held through reset
        spi_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_outs(1'b0, k == 4, 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b1;
        #1;
        check("midreset_phase", 32'(phase), 32'd0);
        check("midreset_clk_cpu", 32'(clk_cpu), 32'd0);
        expect_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        tph   = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            expect_outs(tph >= 8, (k == 4) || (k == 5), k == 6, 1'b0, 1'b0);
        end
        spi_valid = 1'b0;
        run_plain(16, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
